// File: rtl/pc_gen.sv
// pc_gen: registered fetch program-counter generator.
// Holds the current PC, steps it on accepted fetches, arbitrates prioritised
// redirect sources and inserts a flush bubble after each redirect.
// Optional feature macro: PC_GEN_RVC_EN (compressed-instruction support).
module pc_gen #(
    parameter int unsigned    XLEN         = 32,
    parameter int unsigned    NUM_REDIR    = 2,
    parameter logic [XLEN-1:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned    FLUSH_CYCLES = 1
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [NUM_REDIR-1:0]      redir_en,
    input  logic [NUM_REDIR*XLEN-1:0] redir_addr,
    input  logic                      pc_ready,
    input  logic [1:0]                ins_2bit,
    output logic [XLEN-1:0]           pc,
    output logic [XLEN-1:0]           pc_add2,
    output logic                      pc_valid,
    output logic [XLEN-1:0]           next_pc,
    output logic [XLEN-1:0]           next_pc_add2,
    output logic                      misalign_err
);

    localparam int unsigned CNT_W = 4;

`ifdef PC_GEN_RVC_EN
    localparam logic [1:0] ALIGN_MASK = 2'b01;
`else
    localparam logic [1:0] ALIGN_MASK = 2'b11;
`endif

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    logic            redir_hit;
    logic [XLEN-1:0] redir_tgt;
    logic [XLEN-1:0] tgt_aligned;
    logic            tgt_misaligned;
    logic [XLEN-1:0] step_amt;
    logic            stepping;

    // Redirect arbitration: highest set index wins.
    always_comb begin
        redir_hit = 1'b0;
        redir_tgt = '0;
        for (int i = 0; i < int'(NUM_REDIR); i++) begin
            if (redir_en[i]) begin
                redir_hit = 1'b1;
                redir_tgt = redir_addr[i*XLEN +: XLEN];
            end
        end
    end

    // Target alignment: clear the low bits that must be zero and flag them if set.
    always_comb begin
        tgt_aligned    = {redir_tgt[XLEN-1:2], redir_tgt[1:0] & ~ALIGN_MASK};
        tgt_misaligned = |(redir_tgt[1:0] & ALIGN_MASK);
    end

`ifdef PC_GEN_RVC_EN
    // Step size: compressed encodings (low bits != 11) advance by 2.
    always_comb begin
        step_amt = (ins_2bit != 2'b11) ? XLEN'(2) : XLEN'(4);
    end
`else
    logic unused_ins_2bit;
    assign unused_ins_2bit = ^ins_2bit;

    // Step size: fixed 4-byte instructions.
    always_comb begin
        step_amt = XLEN'(4);
    end
`endif

    // Next-PC selection: redirect beats step beats hold.
    always_comb begin
        stepping     = (state == RUN) && pc_ready;
        next_pc      = pc;
        if (redir_hit) begin
            next_pc = tgt_aligned;
        end else if (stepping) begin
            next_pc = pc + step_amt;
        end
        next_pc_add2 = next_pc + XLEN'(2);
        pc_add2      = pc + XLEN'(2);
    end

    // Next-state and flush-counter logic.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (redir_hit) begin
            cnt_nxt   = CNT_W'(FLUSH_CYCLES);
            state_nxt = (FLUSH_CYCLES == 0) ? RUN : FLUSH;
        end else begin
            case (state)
                BOOT: state_nxt = RUN;
                RUN:  state_nxt = RUN;
                FLUSH: begin
                    cnt_nxt = cnt - CNT_W'(1);
                    if (cnt <= CNT_W'(1)) begin
                        state_nxt = RUN;
                    end
                end
                default: state_nxt = BOOT;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath registers: pc, bubble counter, valid and misalignment pulse.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            pc           <= RESET_PC;
            cnt          <= '0;
            pc_valid     <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            pc           <= next_pc;
            cnt          <= cnt_nxt;
            pc_valid     <= (state_nxt == RUN);
            misalign_err <= redir_hit && tgt_misaligned;
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed-vector bench for pc_gen with a queue-based scoreboard.
// Honours PC_GEN_RVC_EN to select expected values for compressed support.
module tb_pc_gen;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned NUM_REDIR = 2;

`ifdef PC_GEN_RVC_EN
    localparam bit RVC = 1'b1;
`else
    localparam bit RVC = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic        valid;
        logic        mis;
    } exp_t;

    logic                      clk;
    logic                      rstn;
    logic [NUM_REDIR-1:0]      redir_en;
    logic [NUM_REDIR*XLEN-1:0] redir_addr;
    logic                      pc_ready;
    logic [1:0]                ins_2bit;
    logic [XLEN-1:0]           pc;
    logic [XLEN-1:0]           pc_add2;
    logic                      pc_valid;
    logic [XLEN-1:0]           next_pc;
    logic [XLEN-1:0]           next_pc_add2;
    logic                      misalign_err;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    pc_gen #(
        .XLEN(XLEN),
        .NUM_REDIR(NUM_REDIR),
        .RESET_PC(32'h0000_0000),
        .FLUSH_CYCLES(1)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .redir_en(redir_en),
        .redir_addr(redir_addr),
        .pc_ready(pc_ready),
        .ins_2bit(ins_2bit),
        .pc(pc),
        .pc_add2(pc_add2),
        .pc_valid(pc_valid),
        .next_pc(next_pc),
        .next_pc_add2(next_pc_add2),
        .misalign_err(misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of stimulus and queue the outputs expected after the edge.
    task automatic vec(input logic r, input logic [1:0] en, input logic [31:0] a0,
                       input logic [31:0] a1, input logic rdy, input logic [1:0] ins,
                       input logic [31:0] epc, input logic ev, input logic emis);
        exp_t e;
        @(negedge clk);
        rstn       = r;
        redir_en   = en;
        redir_addr = {a1, a0};
        pc_ready   = rdy;
        ins_2bit   = ins;
        #1;
        if (r) begin
            n_vec++;
            if (next_pc !== epc) begin
                n_err++;
                $display("FAIL next_pc: got %h want %h", next_pc, epc);
            end
            n_vec++;
            if (next_pc_add2 !== epc + 32'd2) begin
                n_err++;
                $display("FAIL next_pc_add2: got %h want %h", next_pc_add2, epc + 32'd2);
            end
        end
        e.pc    = epc;
        e.valid = ev;
        e.mis   = emis;
        q.push_back(e);
        @(posedge clk);
    endtask

    // Monitor: pop one expectation per cycle and compare the registered outputs.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                n_vec++;
                if (pc !== e.pc) begin
                    n_err++;
                    $display("FAIL pc: got %h want %h", pc, e.pc);
                end
                n_vec++;
                if (pc_add2 !== e.pc + 32'd2) begin
                    n_err++;
                    $display("FAIL pc_add2: got %h want %h", pc_add2, e.pc + 32'd2);
                end
                n_vec++;
                if (pc_valid !== e.valid) begin
                    n_err++;
                    $display("FAIL pc_valid at pc %h: got %b want %b", pc, pc_valid, e.valid);
                end
                n_vec++;
                if (misalign_err !== e.mis) begin
                    n_err++;
                    $display("FAIL misalign_err at pc %h: got %b want %b", pc, misalign_err, e.mis);
                end
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Directed stimulus with hand-computed expectations.
    initial begin
        rstn       = 1'b0;
        redir_en   = '0;
        redir_addr = '0;
        pc_ready   = 1'b0;
        ins_2bit   = 2'b11;

        // Reset, boot cycle, then sequential 4-byte steps
        vec(0, 2'b00, 32'h0, 32'h0, 1, 2'b11, 32'h0000_0000, 0, 0);
        vec(1, 2'b00, 32'h0, 32'h0, 1, 2'b11, 32'h0000_0000, 1, 0);
        vec(1, 2'b00, 32'h0, 32'h0, 1, 2'b11, 32'h0000_0004, 1, 0);
        vec(1, 2'b00, 32'h0, 32'h0, 1, 2'b11, 32'h0000_0008, 1, 0);
        vec(1, 2'b00, 32'h0, 32'h0, 1, 2'b11, 32'h0000_000C, 1, 0);
        vec(1, 2'b00, 32'h0, 32'h0, 0, 2'b11, 32'h0000_000C, 1, 0);

        // Redirect to 0x100, flush bubble ignores pc_ready, then compressed-style step
        vec(1, 2'b01, 32'h100, 32'h0, 1, 2'b11, 32'h0000_0100, 0, 0);
        vec(1, 2'b00, 32'h0, 32'h0, 1, 2'b11, 32'h0000_0100, 1, 0);
        vec(1, 2'b00, 32'h0, 32'h0, 1, 2'b01, RVC ? 32'h0000_0102 : 32'h0000_0104, 1, 0);

        // Both sources at once with pc_ready: higher index wins and overrides the step
        vec(1, 2'b11, 32'h200, 32'h300, 1, 2'b11, 32'h0000_0300, 0, 0);
        // Second redirect during the bubble restarts it
        vec(1, 2'b10, 32'h0, 32'h400, 1, 2'b11, 32'h0000_0400, 0, 0);
        vec(1, 2'b00, 32'h0, 32'h0, 0, 2'b11, 32'h0000_0400, 1, 0);
        vec(1, 2'b00, 32'h0, 32'h0, 0, 2'b11, 32'h0000_0400, 1, 0);

        // Misaligned targets
        vec(1, 2'b01, 32'h501, 32'h0, 0, 2'b11, 32'h0000_0500, 0, 1);
        vec(1, 2'b00, 32'h0, 32'h0, 0, 2'b11, 32'h0000_0500, 1, 0);
        vec(1, 2'b01, 32'h502, 32'h0, 0, 2'b11, RVC ? 32'h0000_0502 : 32'h0000_0500, 0, !RVC);
        vec(1, 2'b00, 32'h0, 32'h0, 0, 2'b11, RVC ? 32'h0000_0502 : 32'h0000_0500, 1, 0);

        // Address wrap at the top of the space
        vec(1, 2'b10, 32'h0, 32'hFFFF_FFFC, 0, 2'b11, 32'hFFFF_FFFC, 0, 0);
        vec(1, 2'b00, 32'h0, 32'h0, 0, 2'b11, 32'hFFFF_FFFC, 1, 0);
        vec(1, 2'b00, 32'h0, 32'h0, 1, 2'b11, 32'h0000_0000, 1, 0);

        // Reset mid-flush overrides a simultaneous misaligned redirect
        vec(1, 2'b01, 32'h700, 32'h0, 0, 2'b11, 32'h0000_0700, 0, 0);
        vec(0, 2'b01, 32'h801, 32'h0, 1, 2'b11, 32'h0000_0000, 0, 0);
        vec(1, 2'b00, 32'h0, 32'h0, 1, 2'b11, 32'h0000_0000, 1, 0);
        vec(1, 2'b00, 32'h0, 32'h0, 1, 2'b11, 32'h0000_0004, 1, 0);

        // Drain the scoreboard
        @(negedge clk);
        redir_en = '0;
        pc_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        n_vec++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
